// File: rtl/ledmx_pkg.sv
// Shared constants for the LED-matrix scanner: register map, CTRL bit positions, counter widths.
// Pure definitions, no timing. No flow control.
// Scanner build option: LEDMX_BLANK_EN (see led_matrix_scan.sv).
package ledmx_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_COMMIT = 1;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ledmx_scan_timer.sv
// Column-slot divider and column index counter with frame-wrap pulse.
// Registers update every clk; next-state values are exported combinationally. No backpressure.
// Held at zero whenever i_run is low.
module ledmx_scan_timer
    import ledmx_pkg::*;
#(
    parameter int COLS = 5,
    parameter int DIV  = 50000
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_run,
    output logic [cnt_width(COLS)-1:0]   o_index,
    output logic [cnt_width(COLS)-1:0]   o_index_nxt,
    output logic [cnt_width(DIV)-1:0]    o_div_nxt,
    output logic                         o_wrap
);

    localparam int IW = cnt_width(COLS);
    localparam int DW = cnt_width(DIV);

    logic [DW-1:0] r_div;
    logic [IW-1:0] r_index;
    logic          w_slot_end;
    logic          w_last_col;

    assign w_slot_end = i_run && (r_div == DW'(DIV - 1));
    assign w_last_col = (r_index == IW'(COLS - 1));
    assign o_wrap     = w_slot_end && w_last_col;
    assign o_index    = r_index;

    always_comb begin
        o_div_nxt   = r_div;
        o_index_nxt = r_index;
        if (!i_run) begin
            o_div_nxt   = '0;
            o_index_nxt = '0;
        end else if (w_slot_end) begin
            o_div_nxt   = '0;
            o_index_nxt = w_last_col ? '0 : r_index + IW'(1);
        end else begin
            o_div_nxt   = r_div + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div   <= '0;
            r_index <= '0;
        end else begin
            r_div   <= o_div_nxt;
            r_index <= o_index_nxt;
        end
    end

endmodule

// File: rtl/led_matrix_scan.sv
// Avalon-MM LED-matrix scanner: double-buffered column patterns, one-hot column strobe, frame tick.
// Outputs registered (1 clk after state change), readdata combinational; slave never stalls.
// Option LEDMX_BLANK_EN: blank outputs for the first BLANK cycles of each column slot.
module led_matrix_scan
    import ledmx_pkg::*;
#(
    parameter int COLS  = 5,
    parameter int ROWS  = 7,
    parameter int DIV   = 50000,
    parameter int BLANK = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [2:0]      address,
    input  logic            chipselect,
    input  logic            write_n,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    output logic [COLS-1:0] col_out,
    output logic [ROWS-1:0] row_out,
    output logic            frame_tick
);

    localparam int IW = cnt_width(COLS);
    localparam int DW = cnt_width(DIV);

    logic [ROWS-1:0] r_shadow [COLS];
    logic [ROWS-1:0] r_active [COLS];
    logic            r_enable;
    logic            r_pending;
    logic [COLS-1:0] r_col;
    logic [ROWS-1:0] r_row;
    logic            r_tick;

    logic            w_wr;
    logic            w_ctrl_wr;
    logic            w_en_nxt;
    logic            w_run;
    logic            w_commit;
    logic            w_pend_nxt;
    logic            w_wrap;
    logic [IW-1:0]   w_index;
    logic [IW-1:0]   w_index_nxt;
    logic [DW-1:0]   w_div_nxt;
    logic [ROWS-1:0] w_active_nxt [COLS];
    logic [COLS-1:0] w_col_nxt;
    logic [ROWS-1:0] w_row_nxt;
    logic [31:0]     w_rd;
    logic            w_unused;

    assign w_wr      = chipselect && !write_n;
    assign w_ctrl_wr = w_wr && (address == ADDR_CTRL);
    assign w_en_nxt  = w_ctrl_wr ? writedata[CTRL_EN] : r_enable;
    // The timer runs only while enable is set both now and after this edge, so
    // enabling starts from slot 0 and disabling zeroes the counters immediately.
    assign w_run     = r_enable && w_en_nxt;

    ledmx_scan_timer #(
        .COLS (COLS),
        .DIV  (DIV)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_run       (w_run),
        .o_index     (w_index),
        .o_index_nxt (w_index_nxt),
        .o_div_nxt   (w_div_nxt),
        .o_wrap      (w_wrap)
    );

    assign w_commit   = r_pending && (r_enable ? w_wrap : 1'b1);
    assign w_pend_nxt = (w_ctrl_wr && writedata[CTRL_COMMIT]) ? 1'b1 :
                        w_commit                              ? 1'b0 : r_pending;

    always_comb begin
        for (int i = 0; i < COLS; i++) begin
            w_active_nxt[i] = w_commit ? r_shadow[i] : r_active[i];
        end
    end

    // Output registers are loaded from next-state index/active so they change on the same edge.
    always_comb begin
        w_col_nxt = '0;
        w_row_nxt = '0;
        for (int i = 0; i < COLS; i++) begin
            if (w_en_nxt && (w_index_nxt == IW'(i))) begin
                w_col_nxt[i] = 1'b1;
                w_row_nxt    = w_active_nxt[i];
            end
        end
`ifdef LEDMX_BLANK_EN
        if (w_div_nxt < DW'(BLANK)) begin
            w_col_nxt = '0;
            w_row_nxt = '0;
        end
`endif
    end

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < COLS; i++) begin
            if (address == 3'(i)) begin
                w_rd[ROWS-1:0] = r_shadow[i];
            end
        end
        if (address == ADDR_CTRL) begin
            w_rd[CTRL_EN]     = r_enable;
            w_rd[CTRL_COMMIT] = r_pending;
        end
        if (address == ADDR_STATUS) begin
            w_rd[IW-1:0] = w_index;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < COLS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_enable  <= 1'b0;
            r_pending <= 1'b0;
            r_col     <= '0;
            r_row     <= '0;
            r_tick    <= 1'b0;
        end else begin
            for (int i = 0; i < COLS; i++) begin
                if (w_wr && (address == 3'(i))) begin
                    r_shadow[i] <= writedata[ROWS-1:0];
                end
                r_active[i] <= w_active_nxt[i];
            end
            r_enable  <= w_en_nxt;
            r_pending <= w_pend_nxt;
            r_col     <= w_col_nxt;
            r_row     <= w_row_nxt;
            r_tick    <= w_wrap;
        end
    end

    assign readdata   = w_rd;
    assign col_out    = r_col;
    assign row_out    = r_row;
    assign frame_tick = r_tick;

    assign w_unused = ^{writedata, w_div_nxt};

endmodule
